// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: CPU stores feed a small byte FIFO that is
// serialised LSB first on tx; a status word is readable with one-cycle latency.
module uart_tx_periph #(
  parameter logic [9:0] ADDR_DATA       = 10'h3F0,
  parameter logic [9:0] ADDR_STATUS     = 10'h3F4,
  parameter int         CLKS_PER_BIT    = 104,
  parameter int         FIFO_DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  address,
  input  logic [31:0] data,
  input  logic [3:0]  width,
  input  logic        write,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy
);

  localparam int DEPTH  = 1 << FIFO_DEPTH_LOG2;
  localparam int CNT_W  = FIFO_DEPTH_LOG2 + 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  function automatic logic [31:0] pack_status(input logic [CNT_W-1:0] cnt,
                                              input logic ovf,
                                              input logic full,
                                              input logic bsy);
    logic [3:0] cnt4;
    cnt4 = 4'(cnt);
    return {24'd0, cnt4, 1'b0, ovf, full, bsy};
  endfunction

  // FIFO state
  logic [7:0]                 r_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
  logic [CNT_W-1:0]           r_count;
  logic                       r_ovf;

  // Serialiser state
  state_t            r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_idx;
  logic [7:0]        r_shift;
  logic              r_tx;
  logic [31:0]       r_rdata;

  logic w_push_req, w_full, w_empty, w_pop, w_push;
  logic w_ovf_set, w_ovf_clr, w_busy, w_baud_done;
  logic [7:0] w_head;

  state_t            w_state_nxt;
  logic [BAUD_W-1:0] w_baud_nxt;
  logic [2:0]        w_idx_nxt;
  logic [7:0]        w_shift_nxt;
  logic              w_tx_nxt;

  // Upper store lanes carry nothing this peripheral consumes.
  logic w_unused;
  assign w_unused = &{1'b0, data[31:8], width[3:1]};

  assign w_push_req  = write && (address == ADDR_DATA) && width[0];
  assign w_ovf_clr   = write && (address == ADDR_STATUS) && width[0] && data[2];
  assign w_full      = (r_count == CNT_FULL);
  assign w_empty     = (r_count == '0);
  assign w_pop       = (r_state == IDLE) && !w_empty;
  // A pop on the same edge frees a slot, so a push into a full FIFO is still accepted.
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_ovf_set   = w_push_req && w_full && !w_pop;
  assign w_busy      = (r_state != IDLE) || !w_empty;
  assign w_baud_done = (r_baud == BAUD_LAST);
  assign w_head      = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data[7:0];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_state_nxt = START;
          w_baud_nxt  = '0;
          w_shift_nxt = w_head;
        end
      end
      START: begin
        if (w_baud_done) begin
          w_state_nxt = DATA;
          w_baud_nxt  = '0;
          w_idx_nxt   = 3'd0;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      DATA: begin
        if (w_baud_done) begin
          w_baud_nxt = '0;
          if (r_idx == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      STOP: begin
        if (w_baud_done) begin
          w_state_nxt = IDLE;
          w_baud_nxt  = '0;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // tx is decoded from the next state so the pin register lines up with the state register.
    unique case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_idx   <= 3'd0;
      r_tx    <= 1'b1;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_idx   <= w_idx_nxt;
      r_tx    <= w_tx_nxt;
      r_rdata <= (address == ADDR_STATUS) ? pack_status(r_count, r_ovf, w_full, w_busy) : '0;
    end
  end

  always_ff @(posedge clk) begin
    r_shift <= w_shift_nxt;
  end

  assign tx    = r_tx;
  assign busy  = w_busy;
  assign rdata = r_rdata;

endmodule
